sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/arbiter_rr2.sv | 42 ++++
 rtl/sram_arbiter.sv | 111 +++++++++++
 tb/tb_sram_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared FSM encodings and op constants for the two-port async SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4
    } state_t;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/arbiter_rr2.sv
// Two-way grant selection: round-robin on contention, or port 0 always wins
// when SRAM_ARBITER_FIXED_PRIORITY_EN is defined.
module arbiter_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
    logic unused_ok;
    assign unused_ok = ^{clk, reset, take_i};

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0])      gnt_o = 2'b01;
        else if (req_i[1]) gnt_o = 2'b10;
    end
`else
    // last_q = 1 means port 1 won most recently, so port 0 wins the next tie
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_q <= 1'b1;
        else if (take_i && (|req_i))
            last_q <= gnt_o[1];
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two requesters sharing one async SRAM: 3 cycles per op, done pulse at accept+3.
// Contention policy selected by SRAM_ARBITER_FIXED_PRIORITY_EN (default round-robin).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [2*DATA_BITS-1:0] req_wdata,
    output logic [1:0]             rsp_done,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic [ADDR_BITS-1:0]   addr_bus,
    inout  wire  [DATA_BITS-1:0]   data_bus,
    output logic                   we_n,
    output logic                   oe_n,
    output logic                   ce_n
);

    state_t                 state_q, state_d;
    logic                   port_q, port_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [1:0]             done_q, done_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [1:0]             gnt;
    logic                   sel;
    logic                   take;

    assign take = (state_q == ST_IDLE) && !reset;
    assign sel  = gnt[1];

    arbiter_rr2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req_valid),
        .take_i (take),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        req_ready = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (take && (|req_valid)) begin
                    req_ready = gnt;
                    port_d    = sel;
                    we_d      = req_we[sel];
                    addr_d    = req_addr[int'(sel)*ADDR_BITS +: ADDR_BITS];
                    wdata_d   = req_wdata[int'(sel)*DATA_BITS +: DATA_BITS];
                    state_d   = (req_we[sel] == OP_WRITE) ? ST_WR0 : ST_RD0;
                end
            end
            ST_WR0: state_d = ST_WR1;
            ST_WR1: begin
                done_d[port_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                done_d[port_q] = 1'b1;
                rdata_d        = data_bus;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            we_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from state so an aborted op releases them immediately
    assign ce_n      = (state_q == ST_IDLE);
    assign we_n      = (state_q != ST_WR0);
    assign oe_n      = !((state_q == ST_RD0) || (state_q == ST_RD1));
    assign addr_bus  = addr_q;
    assign data_bus  = ((state_q == ST_WR0) || (state_q == ST_WR1)) ? wdata_q : {DATA_BITS{1'bz}};
    assign rsp_done  = done_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with an inline behavioural async SRAM.
module tb_sram_arbiter;

    typedef struct {
        int         port;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 0, v1 = 0, we0 = 0, we1 = 0;
    logic [9:0]  a0 = '0, a1 = '0;
    logic [7:0]  d0 = '0, d1 = '0;
    logic [1:0]  req_valid, req_ready, req_we, rsp_done;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rsp_rdata;
    logic [9:0]  addr_bus;
    wire  [7:0]  data_bus;
    logic        we_n, oe_n, ce_n;

    assign req_valid = {v1, v0};
    assign req_we    = {we1, we0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_BITS(10), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .we_n      (we_n),
        .oe_n      (oe_n),
        .ce_n      (ce_n)
    );

    // SRAM: commits a write once we_n has pulsed low and the hold cycle completes
    logic [7:0] mem [0:1023];
    logic       prev_we_low = 1'b0;
    assign data_bus = (!ce_n && !oe_n) ? mem[addr_bus] : 8'hzz;

    always @(posedge clk) begin
        if (prev_we_low && !ce_n && we_n) mem[addr_bus] <= data_bus;
        prev_we_low <= !we_n && !ce_n;
    end

    int   checks = 0, passes = 0;
    int   cyc = 0, dbl = 0, we_run = 0, we_bad = 0, we_pulses = 0, prio_bad = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    exp_t e;
    int   acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic expect_rsp(input int p, input bit rd, input logic [7:0] d);
        exp_t x;
        x.port = p; x.rd = rd; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic issue(input int p, input bit we, input logic [9:0] a, input logic [7:0] d,
                         output int acc_cyc);
        int n = 0;
        bit ok = 0;
        acc_cyc = -1;
        if (p == 0) begin v0 = 1; we0 = we; a0 = a; d0 = d; end
        else        begin v1 = 1; we1 = we; a1 = a; d1 = d; end
        while (!ok && n < 40) begin
            @(negedge clk);
            if (req_ready[p]) begin ok = 1; acc_cyc = cyc; end
            n++;
        end
        @(posedge clk); #1;
        if (p == 0) v0 = 0; else v1 = 0;
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: port %0d saw no req_ready within 40 cycles", p);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        cyc++;
        if (!we_n) we_run++;
        else begin
            if (we_run == 1) we_pulses++;
            if (we_run > 1) we_bad++;
            we_run = 0;
        end
        if (reset) acc_q.delete();
        else begin
            if (req_ready == 2'b11) dbl++;
            if (req_ready[1] && req_valid[0]) prio_bad++;
            if (|req_ready) acc_q.push_back(cyc);
            if (rsp_done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: rsp_done=%b with empty scoreboard", rsp_done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_port", {30'd0, rsp_done}, 32'd1 << e.port);
                    if (e.rd) chk("rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
                    if (acc_q.size() != 0) begin
                        acc = acc_q.pop_front();
                        chk("latency", cyc - acc, 3);
                    end
                end
            end
        end
    end

    initial begin
        int c[4];
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Reset state, with a request pending that must not be accepted
        v0 = 1; we0 = 1; a0 = 10'h155; d0 = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_ready", {30'd0, req_ready}, 0);
        chk("rst_strobes", {29'd0, ce_n, we_n, oe_n}, 3'b111);
        chk("rst_addr", {22'd0, addr_bus}, 0);
        chk("rst_done", {30'd0, rsp_done}, 0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 0);
        @(posedge clk); #1;
        v0 = 0; reset = 0;
        @(posedge clk); #1;

        // Port 0 write then read back
        expect_rsp(0, 0, 8'h00); issue(0, 1, 10'h005, 8'hA5, t);
        expect_rsp(0, 1, 8'hA5); issue(0, 0, 10'h005, 8'h00, t);
        drain();

        // Contention held from reset, two writes per port
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
        expect_rsp(0, 0, 0); expect_rsp(0, 0, 0); expect_rsp(1, 0, 0); expect_rsp(1, 0, 0);
`else
        expect_rsp(0, 0, 0); expect_rsp(1, 0, 0); expect_rsp(0, 0, 0); expect_rsp(1, 0, 0);
`endif
        fork
            begin int t0; issue(0, 1, 10'h010, 8'h11, t0); issue(0, 1, 10'h010, 8'h11, t0); end
            begin int t1; issue(1, 1, 10'h020, 8'h22, t1); issue(1, 1, 10'h020, 8'h22, t1); end
        join
        drain();

        // Port 1 alone, four back-to-back reads
        expect_rsp(1, 1, 8'hA5); expect_rsp(1, 1, 8'h11);
        expect_rsp(1, 1, 8'h22); expect_rsp(1, 1, 8'hA5);
        issue(1, 0, 10'h005, 0, c[0]);
        issue(1, 0, 10'h010, 0, c[1]);
        issue(1, 0, 10'h020, 0, c[2]);
        issue(1, 0, 10'h005, 0, c[3]);
        chk("b2b_spacing", c[3] - c[0], 9);
        drain();

        // Reset during WR0 aborts the write
        issue(0, 1, 10'h030, 8'h33, t);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("abort_strobes", {29'd0, ce_n, we_n, oe_n}, 3'b111);
        chk("abort_done", {30'd0, rsp_done}, 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        expect_rsp(0, 1, 8'h00); issue(0, 0, 10'h030, 0, t);
        drain();

        // Address extremes
        expect_rsp(0, 0, 0);     issue(0, 1, 10'h3FF, 8'h5A, t);
        expect_rsp(1, 0, 0);     issue(1, 1, 10'h000, 8'hC3, t);
        expect_rsp(0, 1, 8'h5A); issue(0, 0, 10'h3FF, 0, t);
        expect_rsp(1, 1, 8'hC3); issue(1, 0, 10'h000, 0, t);
        drain();

        repeat (5) @(negedge clk);
        chk("rdata_hold", {24'd0, rsp_rdata}, 8'hC3);
        chk("no_double_ready", dbl, 0);
        chk("we_pulse_len", we_bad, 0);
        chk("we_pulse_count", we_pulses, 8);
`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
        chk("prio_port1_blocked", prio_bad, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
